// File: rtl/hpu_pkg.sv
// Shared definitions for the host-side video memory path: VRAM region map,
// loader command opcodes, loader parser states and pointer arithmetic.
package hpu_pkg;

    // VRAM region base addresses as seen by the pixel processor
    localparam logic [15:0] TILE_OFFSET       = 16'h0000;
    localparam logic [15:0] NAMETABLE_OFFSET  = 16'h1800;
    localparam logic [15:0] ATTR_OFFSET       = 16'h2700;
    localparam logic [15:0] PALETTE_OFFSET    = 16'h2AC0;
    localparam logic [15:0] VRAM_SIZE_DEFAULT = 16'h2B00;

    // Loader command opcodes (first byte of every command)
    localparam logic [7:0] OP_ADDR  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_FILL  = 8'h03;

    // Loader parser states
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR_HI  = 4'd1,
        ST_ADDR_LO  = 4'd2,
        ST_WR_LEN   = 4'd3,
        ST_WR_DATA  = 4'd4,
        ST_FILL_HI  = 4'd5,
        ST_FILL_LO  = 4'd6,
        ST_FILL_VAL = 4'd7,
        ST_FILL_RUN = 4'd8
    } loader_state_e;

    // Advance a VRAM pointer, wrapping to 0 at the end of the address space
    function automatic logic [15:0] ptr_next(input logic [15:0] ptr,
                                             input logic [15:0] size);
        logic [15:0] inc;
        inc = ptr + 16'd1;
        return (inc == size) ? 16'd0 : inc;
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Small write buffer between the command parser and the VRAM commit stage.
// Entries are {addr, data}. A push while full or a pop while empty is ignored;
// fullness is judged on the current occupancy only, so a pop in the same cycle
// does not make room for a push.
module vram_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Read/write pointers; reset flushes the buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/vram_loader.sv
// Host-side VRAM writer. Parses the byte command stream (ADDR / WRITE / FILL),
// queues the resulting (addr, data) writes in a small FIFO and commits one per
// cycle to the VRAM write port while the display side allows it.
//
// Handshake: a byte on rx_data transfers at a rising edge where
// rx_valid && rx_ready; rx_ready never depends on rx_valid, and rx_valid may
// be raised or dropped freely between transfers.
module vram_loader
    import hpu_pkg::*;
#(
    parameter logic [15:0] VRAM_SIZE  = VRAM_SIZE_DEFAULT,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        wr_allow,
    output logic        vram_we,
    output logic [15:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic        busy,
    output logic        cmd_error
);

    loader_state_e state_q;
    logic [15:0]   ptr_q;
    logic [7:0]    addr_hi_q;
    logic [8:0]    wr_cnt_q;
    logic [15:0]   fill_cnt_q;
    logic [7:0]    fill_val_q;
    logic          cmd_error_q;
    logic          vram_we_q;
    logic [15:0]   vram_addr_q;
    logic [7:0]    vram_wdata_q;

    logic          rx_ready_c;
    logic          rx_fire;
    logic          push_c;
    logic [23:0]   push_data_c;
    logic          pop_c;
    logic [23:0]   fifo_head;
    logic          fifo_full;
    logic          fifo_empty;

    // Byte acceptance depends on parser state; data bytes wait for FIFO room
    always_comb begin
        rx_ready_c = 1'b1;
        case (state_q)
            ST_WR_DATA:  rx_ready_c = !fifo_full;
            ST_FILL_RUN: rx_ready_c = 1'b0;
            default:     rx_ready_c = 1'b1;
        endcase
        if (reset) rx_ready_c = 1'b0;
    end

    assign rx_fire = rx_valid && rx_ready_c;

    // FIFO push source: incoming data byte in WRITE, stored value in FILL
    always_comb begin
        push_c      = 1'b0;
        push_data_c = {ptr_q, rx_data};
        if (state_q == ST_WR_DATA) begin
            push_c = rx_fire;
        end else if (state_q == ST_FILL_RUN) begin
            push_c      = !fifo_full;
            push_data_c = {ptr_q, fill_val_q};
        end
    end

    assign pop_c = !fifo_empty && wr_allow;

    vram_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_c),
        .push_data_i (push_data_c),
        .pop_i       (pop_c),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Command parser: state, pointer, counters and the error pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            addr_hi_q   <= '0;
            wr_cnt_q    <= '0;
            fill_cnt_q  <= '0;
            fill_val_q  <= '0;
            cmd_error_q <= 1'b0;
        end else begin
            cmd_error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_fire) begin
                        case (rx_data)
                            OP_ADDR:  state_q <= ST_ADDR_HI;
                            OP_WRITE: state_q <= ST_WR_LEN;
                            OP_FILL:  state_q <= ST_FILL_HI;
                            default:  cmd_error_q <= 1'b1;
                        endcase
                    end
                end
                ST_ADDR_HI: begin
                    if (rx_fire) begin
                        addr_hi_q <= rx_data;
                        state_q   <= ST_ADDR_LO;
                    end
                end
                ST_ADDR_LO: begin
                    if (rx_fire) begin
                        if ({addr_hi_q, rx_data} >= VRAM_SIZE) begin
                            ptr_q       <= '0;
                            cmd_error_q <= 1'b1;
                        end else begin
                            ptr_q <= {addr_hi_q, rx_data};
                        end
                        state_q <= ST_IDLE;
                    end
                end
                ST_WR_LEN: begin
                    if (rx_fire) begin
                        // A length byte of 0 means a full 256-byte burst
                        wr_cnt_q <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        state_q  <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (rx_fire) begin
                        ptr_q    <= ptr_next(ptr_q, VRAM_SIZE);
                        wr_cnt_q <= wr_cnt_q - 9'd1;
                        if (wr_cnt_q == 9'd1) state_q <= ST_IDLE;
                    end
                end
                ST_FILL_HI: begin
                    if (rx_fire) begin
                        fill_cnt_q[15:8] <= rx_data;
                        state_q          <= ST_FILL_LO;
                    end
                end
                ST_FILL_LO: begin
                    if (rx_fire) begin
                        fill_cnt_q[7:0] <= rx_data;
                        state_q         <= ST_FILL_VAL;
                    end
                end
                ST_FILL_VAL: begin
                    if (rx_fire) begin
                        fill_val_q <= rx_data;
                        state_q    <= (fill_cnt_q == 16'd0) ? ST_IDLE : ST_FILL_RUN;
                    end
                end
                ST_FILL_RUN: begin
                    if (!fifo_full) begin
                        ptr_q      <= ptr_next(ptr_q, VRAM_SIZE);
                        fill_cnt_q <= fill_cnt_q - 16'd1;
                        if (fill_cnt_q == 16'd1) state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Commit stage: one registered write strobe per FIFO pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vram_we_q    <= 1'b0;
            vram_addr_q  <= '0;
            vram_wdata_q <= '0;
        end else begin
            vram_we_q <= pop_c;
            if (pop_c) begin
                vram_addr_q  <= fifo_head[23:8];
                vram_wdata_q <= fifo_head[7:0];
            end
        end
    end

    assign rx_ready   = rx_ready_c;
    assign vram_we    = vram_we_q;
    assign vram_addr  = vram_addr_q;
    assign vram_wdata = vram_wdata_q;
    assign cmd_error  = cmd_error_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty || vram_we_q;

endmodule

// File: tb/tb_vram_loader.sv
// Bench for vram_loader: directed command scenarios followed by random command
// streams. Commands update a reference pointer and push expected writes into a
// queue; an independent monitor pops and compares every VRAM write strobe.
module tb_vram_loader;

    localparam logic [15:0] VSIZE = 16'h2B00;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_allow;
    logic        vram_we;
    logic [15:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        busy;
    logic        cmd_error;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [23:0] exp_q[$];
    int          ptr_m       = 0;
    int          err_exp     = 0;
    int          err_seen    = 0;
    int          cur_run     = 0;
    int          max_run     = 0;
    logic        allow_at_edge = 1'b0;
    bit          rnd_allow   = 1'b0;
    bit          gaps        = 1'b0;
    logic [7:0]  pay[256];

    // Clock and DUT
    always #5 clk = ~clk;

    vram_loader #(
        .VRAM_SIZE  (VSIZE),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .wr_allow   (wr_allow),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .busy       (busy),
        .cmd_error  (cmd_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected entry
    always @(posedge clk) allow_at_edge <= wr_allow;

    always @(negedge clk) begin
        logic [23:0] e;
        if (cmd_error) err_seen++;
        if (vram_we) begin
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
            check("we_needs_allow", {31'd0, allow_at_edge}, 32'd1);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", vram_addr, vram_wdata);
            end else begin
                e = exp_q.pop_front();
                check("vram_addr", {16'd0, vram_addr}, {16'd0, e[23:8]});
                check("vram_wdata", {24'd0, vram_wdata}, {24'd0, e[7:0]});
            end
        end else begin
            cur_run = 0;
        end
    end

    // One cycle step; optionally randomizes wr_allow
    task automatic tick();
        @(negedge clk);
        if (rnd_allow) wr_allow = ($urandom_range(0, 3) != 0);
    endtask

    // Present a byte and return at the negedge after it was accepted
    task automatic send_byte(input logic [7:0] b);
        int n;
        if (gaps && $urandom_range(0, 3) == 0) begin
            rx_valid = 1'b0;
            tick();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 3000) begin
            tick();
            n++;
        end
        if (!rx_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_ready_timeout: got 0 expected 1 at %0t", $time);
        end
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic cmd_addr(input logic [7:0] hi, input logic [7:0] lo);
        int a;
        a = {16'd0, hi, lo};
        send_byte(8'h01);
        send_byte(hi);
        send_byte(lo);
        if (a >= VSIZE) begin
            ptr_m = 0;
            err_exp++;
            check("addr_error_pulse", {31'd0, cmd_error}, 32'd1);
        end else begin
            ptr_m = a;
            check("addr_no_error", {31'd0, cmd_error}, 32'd0);
        end
    endtask

    // Burst of n bytes from pay[]; n=256 is sent as length byte 0
    task automatic cmd_write(input int n);
        logic [8:0] len;
        len = n[8:0];
        send_byte(8'h02);
        send_byte(len[7:0]);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({ptr_m[15:0], pay[i]});
            ptr_m = (ptr_m + 1) % VSIZE;
            send_byte(pay[i]);
        end
    endtask

    task automatic cmd_fill(input logic [15:0] cnt, input logic [7:0] v);
        send_byte(8'h03);
        send_byte(cnt[15:8]);
        send_byte(cnt[7:0]);
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back({ptr_m[15:0], v});
            ptr_m = (ptr_m + 1) % VSIZE;
        end
        send_byte(v);
        if (cnt != 0) check("fill_rx_ready_low", {31'd0, rx_ready}, 32'd0);
        else          check("fill_zero_idle", {31'd0, rx_ready}, 32'd1);
    endtask

    task automatic bad_op(input logic [7:0] b);
        send_byte(b);
        err_exp++;
        check("bad_op_error", {31'd0, cmd_error}, 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 5000) begin
            tick();
            n++;
        end
        check("drain_busy", {31'd0, busy}, 32'd0);
        check("drain_pending", exp_q.size(), 32'd0);
    endtask

    // Stimulus
    initial begin
        int n;
        int kind;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        wr_allow = 1'b0;
        #1;
        check("rst_vram_we", {31'd0, vram_we}, 32'd0);
        check("rst_vram_addr", {16'd0, vram_addr}, 32'd0);
        check("rst_vram_wdata", {24'd0, vram_wdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cmd_error", {31'd0, cmd_error}, 32'd0);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("post_rst_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Burst into the nametable on consecutive cycles, then busy falls
        wr_allow = 1'b1;
        cmd_addr(8'h18, 8'h00);
        pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
        max_run = 0;
        cmd_write(3);
        n = 0;
        while (!(vram_we && vram_wdata == 8'hCC) && n < 50) begin
            tick();
            n++;
        end
        tick();
        check("busy_after_last_we", {31'd0, busy}, 32'd0);
        check("consecutive_writes", max_run, 32'd3);
        wait_drain();

        // Pointer wrap at the top of VRAM
        cmd_addr(8'h2A, 8'hFF);
        pay[0] = 8'h11; pay[1] = 8'h22;
        cmd_write(2);
        wait_drain();

        // Stalled commits: four bytes fill the buffer, rx_ready drops
        wr_allow = 1'b0;
        cmd_addr(8'h01, 8'h00);
        send_byte(8'h02);
        send_byte(8'h08);
        for (int i = 0; i < 8; i++) begin
            pay[i] = 8'($urandom_range(0, 255));
            exp_q.push_back({ptr_m[15:0], pay[i]});
            ptr_m = (ptr_m + 1) % VSIZE;
        end
        for (int i = 0; i < 4; i++) send_byte(pay[i]);
        rx_data  = pay[4];
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rx_ready_full", {31'd0, rx_ready}, 32'd0);
        end
        wr_allow = 1'b1;
        for (int i = 4; i < 8; i++) send_byte(pay[i]);
        wait_drain();

        // Fill of the attribute region
        cmd_addr(8'h27, 8'h00);
        cmd_fill(16'd5, 8'h7E);
        wait_drain();
        cmd_fill(16'd0, 8'h33);
        wait_drain();

        // Protocol errors, then a write lands at 0
        bad_op(8'h55);
        cmd_addr(8'hFF, 8'hFF);
        pay[0] = 8'h01;
        cmd_write(1);
        wait_drain();
        check("error_count_directed", err_seen, err_exp);

        // Reset in the middle of a WRITE with buffered entries
        cmd_addr(8'h01, 8'h00);
        pay[0] = 8'hC3;
        cmd_write(1);
        wait_drain();
        wr_allow = 1'b0;
        send_byte(8'h02);
        send_byte(8'h05);
        send_byte(8'h91);
        send_byte(8'h92);
        reset = 1'b1;
        #1;
        check("midrst_vram_we", {31'd0, vram_we}, 32'd0);
        check("midrst_vram_addr", {16'd0, vram_addr}, 32'd0);
        check("midrst_vram_wdata", {24'd0, vram_wdata}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_rx_ready", {31'd0, rx_ready}, 32'd0);
        wr_allow = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_we", {31'd0, vram_we}, 32'd0);
        end
        exp_q.delete();
        ptr_m = 0;
        reset = 1'b0;
        tick();
        pay[0] = 8'h5A;
        cmd_write(1);
        wait_drain();

        // Random command streams with random stalls and byte gaps
        gaps      = 1'b1;
        rnd_allow = 1'b1;
        for (int c = 0; c < 60; c++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 2) begin
                if ($urandom_range(0, 2) == 0)
                    cmd_addr(8'h2A, 8'($urandom_range(8'hF0, 8'hFF)));
                else
                    cmd_addr(8'($urandom_range(0, 8'h2F)), 8'($urandom_range(0, 255)));
            end else if (kind <= 5) begin
                n = ($urandom_range(0, 15) == 0) ? 256 : int'($urandom_range(1, 24));
                for (int i = 0; i < n; i++) pay[i] = 8'($urandom_range(0, 255));
                cmd_write(n);
            end else if (kind <= 8) begin
                cmd_fill(16'($urandom_range(0, 20)), 8'($urandom_range(0, 255)));
            end else begin
                bad_op(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(4, 255)));
            end
        end
        rnd_allow = 1'b0;
        gaps      = 1'b0;
        wr_allow  = 1'b1;
        wait_drain();
        check("error_count_total", err_seen, err_exp);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule

// File: doc/vram_loader.md
# vram_loader

Host-side writer for the video memory that the pixel processor reads. Accepts a byte-stream command protocol (address set, burst write, fill), buffers the resulting writes in a small FIFO, and commits them to the VRAM write port whenever the display side permits. Sits between the host/UART receiver and the VRAM write port, opposite the pixel processor's read port.

## Interface

Parameters:
- VRAM_SIZE, 16'h2B00, number of addressable bytes; pointer wraps to 0 at this value.
- FIFO_DEPTH, 4, write-buffer entries (power of two).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- rx_data  in  8  command/data byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte accepted when rx_valid && rx_ready.
- wr_allow  in  1  commit enable; commits stall while low.
- vram_we  out  1  write strobe, registered.
- vram_addr  out  16  write address, registered.
- vram_wdata  out  8  write data, registered.
- busy  out  1  command in progress, FIFO non-empty, or vram_we high.
- cmd_error  out  1  one-cycle pulse on a protocol error.

## Operation

- Opcodes, first byte in IDLE:
  - 0x01 ADDR hi lo: pointer <= {hi,lo}. If {hi,lo} >= VRAM_SIZE: pointer <= 0, cmd_error pulse.
  - 0x02 WRITE n d0..: n data bytes, n=0 means 256. Each byte is pushed as (pointer, d) and the pointer advances.
  - 0x03 FILL nh nl v: {nh,nl} writes of v from the pointer; count 0 is a no-op and returns to IDLE.
  - Any other byte: cmd_error pulse, stay in IDLE.
- States: IDLE, ADDR_HI, ADDR_LO, WR_LEN, WR_DATA, FILL_HI, FILL_LO, FILL_VAL, FILL_RUN.
  - IDLE -> ADDR_HI / WR_LEN / FILL_HI on opcode.
  - ADDR_HI -> ADDR_LO -> IDLE.
  - WR_LEN -> WR_DATA; WR_DATA -> IDLE after the last byte.
  - FILL_HI -> FILL_LO -> FILL_VAL -> FILL_RUN, or -> IDLE for count 0.
  - FILL_RUN -> IDLE after the last push.
- Pointer increment: pointer+1 == VRAM_SIZE gives 0. Applies to WRITE and FILL.
- rx_ready:
  - 1 in IDLE, ADDR_*, WR_LEN, FILL_HI/LO/VAL.
  - In WR_DATA, equals FIFO not-full.
  - 0 in FILL_RUN and while reset is asserted.
- FILL_RUN pushes one entry per cycle while the FIFO is not full. No bypass: a full FIFO blocks a push even when a pop occurs in the same cycle.
- Commit: when the FIFO is non-empty and wr_allow=1, pop at the edge. vram_we/addr/wdata are valid for exactly one cycle after the pop. Otherwise vram_we=0; addr/wdata hold their last values.
- Width rules: the 16-bit count decrements to 0. WRITE length is an 8-bit counter, 0 treated as 256 via 9-bit load.
- Reset mid-command: partial command discarded, FIFO flushed, pointer 0, state IDLE.

## Timing

- Reset values: vram_we 0, vram_addr 0, vram_wdata 0, busy 0, cmd_error 0, rx_ready 0 during reset, 1 after deassertion (IDLE).
- Data byte handshake at edge N: push at N. vram_we is high in cycle N+1 at the earliest, provided wr_allow=1 in the cycle ending at edge N+1.
- Steady-state throughput: 1 write per cycle with wr_allow held high.
- wr_allow low for K cycles delays commits K cycles; no entry is lost or reordered.
- cmd_error is asserted the cycle after the offending byte is accepted.
- busy falls in the cycle after the final vram_we pulse.

## Structure

- Shared package hpu_pkg:
  - VRAM region constants TILE_OFFSET 16'h0, NAMETABLE_OFFSET 16'h1800, ATTR_OFFSET 16'h2700, PALETTE_OFFSET 16'h2AC0.
  - Opcode constants and the loader state enum.
- Sub-module vram_wr_fifo: 24-bit entries {addr, data}, FIFO_DEPTH deep, push/pop/full/empty, async reset.
- Top level holds the parser FSM, pointer/count registers, commit register stage, and busy/error logic.

## Test plan

- ADDR 0x18 0x00, WRITE 3 {AA,BB,CC}, wr_allow=1 -> vram_we pulses at 0x1800/AA, 0x1801/BB, 0x1802/CC on consecutive cycles; busy then falls.
- ADDR 0x2A 0xFF, WRITE 2 {11,22} with VRAM_SIZE=0x2B00 -> writes at 0x2AFF then 0x0000 (wrap).
- wr_allow=0, WRITE 8 bytes -> 4 accepted, rx_ready drops. Raise wr_allow -> all 8 written in order, no drop.
- FILL 0x00 0x05 0x7E at pointer 0x2700 -> five writes 0x2700..0x2704 of 7E. rx_ready stays 0 until the FILL returns to IDLE.
- Opcode 0x55, then ADDR 0xFF 0xFF -> two cmd_error pulses; pointer 0; next WRITE 1 {01} lands at 0x0000.
- Reset asserted during WRITE after 2 of 5 bytes, FIFO holding an entry -> no further vram_we; outputs 0. After release, a fresh command behaves from pointer 0.
